ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle RV32M multiply/divide execution unit in the EX stage, directly downstream of the ID/EX pipeline register. Consumes the registered operands and FUNC3 of an M-extension instruction, raises a stall toward the front of the pipeline while it works, and presents a 32-bit result to the EX/MEM path. Multiplies complete in 1 working cycle. Divides use a 32-iteration restoring algorithm with early exit for the RISC-V special cases.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high; sampled on CLK rising edge.
- START  in  1  ID/EX output: the instruction in EX is an M-extension op.
- FUNC3_IN  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1_IN  in  32  rs1 operand (dividend / multiplicand).
- DATA2_IN  in  32  rs2 operand (divisor / multiplier).
- BUSYWAIT  in  1  memory stall; freezes the unit in DONE.
- FLUSH  in  1  branch/jump flush; aborts any operation.
- RESULT_OUT  out  32  registered result.
- BUSY_OUT  out  1  stall request to PC, IF/ID and ID/EX.
- DONE_OUT  out  1  RESULT_OUT is valid for the current instruction.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset to IDLE. Reset values: RESULT_OUT=0, DONE_OUT=0, BUSY_OUT=0, all internal registers 0.
- IDLE, START=1, FLUSH=0: capture FUNC3 and operands.
  - FUNC3[2]=0: go to MUL.
  - FUNC3[2]=1, divisor=0 or signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): load the special result and go to MUL, which acts as a 1-cycle pass-through.
  - Otherwise: go to DIV with iteration counter=0.
- MUL: form the 64-bit product with per-op signedness.
  - MULH: signed×signed. MULHSU: signed×unsigned. MULHU: unsigned×unsigned.
  - MUL returns the low 32 bits; the other multiply ops return the high 32 bits.
  - Register the result into RESULT_OUT and go to DONE.
- DIV:
  - Operate on magnitudes. For signed ops, |x| is taken in two's complement.
  - Each cycle performs one restoring step: shift remainder left, bring in the next dividend MSB, subtract the divisor, and restore if the difference is negative. Increment the counter.
  - After the 32nd step (counter 31 → wrap), apply signs and go to DONE.
  - Signed quotient is negated if operand signs differ; signed remainder takes the dividend's sign.
  - RESULT_OUT = quotient for DIV/DIVU, remainder for REM/REMU.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU); remainder = DATA1.
  - Overflow: quotient 0x80000000, remainder 0.
- DONE: DONE_OUT=1. If BUSYWAIT=0, return to IDLE on the next edge; if BUSYWAIT=1, stay in DONE.
  - START is still high in DONE because the same instruction is held; it must not restart the unit.
  - A back-to-back M-op is accepted only from IDLE in the following cycle.
- RESULT_OUT holds its value until the next capture; it is not cleared on return to IDLE.
- FLUSH=1 in any state: go to IDLE on the next edge, DONE_OUT=0, RESULT_OUT unchanged. A START seen in the same cycle as FLUSH is ignored.
- RESET has priority over FLUSH, and FLUSH has priority over START.

## Timing
- BUSY_OUT is combinational: (IDLE & START & ~FLUSH) | MUL | DIV. It is 0 in DONE, so the pipeline advances at the edge leaving DONE.
- Multiply and special-case divide:
  - Cycle 0 (IDLE, START): BUSY=1.
  - Cycle 1 (MUL): BUSY=1.
  - Cycle 2 (DONE): BUSY=0, DONE=1, RESULT valid. Stall is 2 cycles.
- Normal divide:
  - Cycle 0 (IDLE, START): BUSY=1.
  - Cycles 1–32 (DIV): BUSY=1.
  - Cycle 33 (DONE): RESULT valid. Stall is 33 cycles.
- RESET asserted mid-operation: all outputs at reset values in the cycle after the edge; no partial result is ever exposed.

## Test plan
- MUL 7×(-3) (0x00000007, 0xFFFFFFFD) → BUSY high 2 cycles, then DONE=1 with RESULT=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → RESULT=0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV -7/2 → quotient 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14. Each with BUSY high exactly 33 cycles and DONE in cycle 33.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Each completes in 2-cycle latency.
- DIV in progress, RESET=1 at iteration 10 → next cycle IDLE, BUSY=0, DONE=0, RESULT=0. Then START MUL 3×4 → RESULT=12 with normal timing.
- DONE with BUSYWAIT=1 for 3 cycles → DONE held and RESULT stable, no restart despite START=1. FLUSH during DIV → IDLE next cycle, RESULT keeps its previous value.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3_IN,
    input  logic [XLEN-1:0] DATA1_IN,
    input  logic [XLEN-1:0] DATA2_IN,
    input  logic            BUSYWAIT,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT_OUT,
    output logic            BUSY_OUT,
    output logic            DONE_OUT
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        func3_q;
    logic [XLEN-1:0]   op_a, op_b;
    logic              special_q;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   quo, rem, div_mag;
    logic              neg_q, neg_r;
    logic [4:0]        count;

    logic              div_by_zero, overflow, div_special, accept, in_signed;
    logic [XLEN-1:0]   special_val;
    logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN:0]     rem_shift, diff;
    logic [XLEN-1:0]   quo_step, rem_step;

    assign div_by_zero = (DATA2_IN == '0);
    assign overflow    = ~FUNC3_IN[0] && (DATA1_IN == {1'b1, {(XLEN-1){1'b0}}})
                         && (DATA2_IN == '1);
    assign div_special = div_by_zero | overflow;
    assign accept      = (state == S_IDLE) && START && !FLUSH;
    assign in_signed   = ~FUNC3_IN[0];

    // Quotient selects on FUNC3[1]=0, remainder on FUNC3[1]=1.
    always_comb begin
        special_val = '0;
        if (FUNC3_IN[1])
            special_val = div_by_zero ? DATA1_IN : '0;
        else
            special_val = div_by_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign mul_a = {{XLEN{(func3_q != 2'b11) & op_a[XLEN-1]}}, op_a};
    assign mul_b = {{XLEN{(func3_q == 2'b01) & op_b[XLEN-1]}}, op_b};
    assign prod  = mul_a * mul_b;

    assign rem_shift = {rem, quo[XLEN-1]};
    assign diff      = rem_shift - {1'b0, div_mag};
    assign quo_step  = {quo[XLEN-2:0], ~diff[XLEN]};
    assign rem_step  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept)
                        state_next = (!FUNC3_IN[2] || div_special) ? S_MUL : S_DIV;
            S_MUL:  state_next = S_DONE;
            S_DIV:  if (count == 5'd31) state_next = S_DONE;
            S_DONE: if (!BUSYWAIT) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (FLUSH) state_next = S_IDLE;
    end

    always_comb begin
        BUSY_OUT = accept || (state == S_MUL) || (state == S_DIV);
        DONE_OUT = (state == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            func3_q     <= '0;
            op_a        <= '0;
            op_b        <= '0;
            special_q   <= 1'b0;
            special_res <= '0;
            quo         <= '0;
            rem         <= '0;
            div_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            count       <= '0;
            RESULT_OUT  <= '0;
        end else if (!FLUSH) begin
            case (state)
                S_IDLE: if (START) begin
                    func3_q     <= FUNC3_IN[1:0];
                    op_a        <= DATA1_IN;
                    op_b        <= DATA2_IN;
                    special_q   <= FUNC3_IN[2] & div_special;
                    special_res <= special_val;
                    quo         <= (in_signed && DATA1_IN[XLEN-1]) ? -DATA1_IN : DATA1_IN;
                    div_mag     <= (in_signed && DATA2_IN[XLEN-1]) ? -DATA2_IN : DATA2_IN;
                    rem         <= '0;
                    neg_q       <= in_signed & (DATA1_IN[XLEN-1] ^ DATA2_IN[XLEN-1]);
                    neg_r       <= in_signed & DATA1_IN[XLEN-1];
                    count       <= '0;
                end
                S_MUL: begin
                    if (special_q)
                        RESULT_OUT <= special_res;
                    else if (func3_q == 2'b00)
                        RESULT_OUT <= prod[XLEN-1:0];
                    else
                        RESULT_OUT <= prod[2*XLEN-1:XLEN];
                end
                S_DIV: begin
                    quo   <= quo_step;
                    rem   <= rem_step;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        if (func3_q[1])
                            RESULT_OUT <= neg_r ? -rem_step : rem_step;
                        else
                            RESULT_OUT <= neg_q ? -quo_step : quo_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, busywait, flush;
    logic [2:0]  func3;
    logic [31:0] d1, d2;
    logic [31:0] result;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK(clk), .RESET(reset), .START(start), .FUNC3_IN(func3),
        .DATA1_IN(d1), .DATA2_IN(d2), .BUSYWAIT(busywait), .FLUSH(flush),
        .RESULT_OUT(result), .BUSY_OUT(busy), .DONE_OUT(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                q = ua / ub; return q[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = ua % ub; return q[31:0];
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2] || b == 0) return 2;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 33;
    endfunction

    // Called shortly after a rising edge with the unit idle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int busy_cycles = 0;
        int n = 0;
        logic [31:0] exp;
        int lat;
        exp = model(f, a, b);
        lat = latency(f, a, b);
        func3 = f; d1 = a; d2 = b; start = 1'b1;
        #1;
        while (!done && n < 60) begin
            if (busy) busy_cycles++;
            n++;
            @(posedge clk); #1;
        end
        check("done_seen", done, 1);
        check("done_cycle", n, lat);
        check("busy_cycles", busy_cycles, lat);
        check("result", result, exp);
        check("busy_in_done", busy, 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_clear", done, 0);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        reset = 1'b1; start = 1'b0; busywait = 1'b0; flush = 1'b0;
        func3 = 3'd0; d1 = 32'h0; d2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_result", result, 32'h0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        run_op(3'd0, 32'h00000007, 32'hFFFFFFFD);
        run_op(3'd1, 32'h80000000, 32'h80000000);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002);
        run_op(3'd4, 32'hFFFFFFF9, 32'h00000002);
        run_op(3'd6, 32'hFFFFFFF9, 32'h00000002);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF);

        // Reset at iteration 10 of a divide.
        func3 = 3'd4; d1 = 32'hFFFFFFF9; d2 = 32'd2; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 32'h0);
        reset = 1'b0;
        run_op(3'd0, 32'd3, 32'd4);

        // Memory stall holds DONE; START stays high and must not restart.
        busywait = 1'b1;
        func3 = 3'd0; d1 = 32'd6; d2 = 32'd7; start = 1'b1;
        n = 0;
        #1;
        while (!done && n < 10) begin n++; @(posedge clk); #1; end
        check("bw_done_seen", done, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bw_done_held", done, 1);
            check("bw_busy_low", busy, 0);
            check("bw_result", result, 32'd42);
        end
        busywait = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("bw_release_done", done, 0);
        check("bw_result_kept", result, 32'd42);

        // Flush mid-divide with START still asserted.
        func3 = 3'd5; d1 = 32'd1000; d2 = 32'd3; start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_done", done, 0);
        check("flush_busy", busy, 0);
        check("flush_result", result, 32'd42);
        flush = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("post_flush_busy", busy, 0);
        check("post_flush_done", done, 0);
        run_op(3'd5, 32'd1000, 32'd3);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int sel;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            run_op(f, a, b);
        end

        held = result;
        @(posedge clk); #1;
        check("idle_result_hold", result, held);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
